// File: rtl/vid_pkg.sv
// rtl/vid_pkg.sv - shared fetch FSM type, bank count and counter width helper.
package vid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    NEXT,
    DRAIN
  } fetch_state_t;

  localparam int unsigned LB_BANKS = 2;

  // Bits needed for a counter that takes the values 0..n-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vid_edge_det.sv
// rtl/vid_edge_det.sv - one-cycle delayed copy of a level with rise/fall strobes.
module vid_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/line_fetch_ctrl.sv
// rtl/line_fetch_ctrl.sv - burst read scheduler filling a ping-pong line buffer ahead of display.
module line_fetch_ctrl
  import vid_pkg::*;
#(
  parameter int unsigned RD_HRES     = 640,
  parameter int unsigned RD_VRES     = 480,
  parameter int unsigned BURST_LEN   = 32,
  parameter int unsigned LINE_STRIDE = 640,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned ADDR_W      = 21
) (
  input  logic              I_pxl_clk,
  input  logic              I_rst_n,
  input  logic              I_vs,
  input  logic              I_rden,
  output logic              O_cmd_valid,
  input  logic              I_cmd_ready,
  output logic [ADDR_W-1:0] O_cmd_addr,
  output logic [7:0]        O_cmd_len,
  input  logic              I_rd_dvalid,
  output logic              O_lb_wr_en,
  output logic              O_lb_wr_sel,
  output logic              O_lb_rd_sel,
  output logic              O_underrun,
  output logic              O_busy
);

  localparam int unsigned BURSTS  = RD_HRES / BURST_LEN;
  localparam int unsigned BEAT_W  = cnt_w(BURST_LEN);
  localparam int unsigned BURST_W = cnt_w(BURSTS);
  localparam int unsigned LINE_W  = cnt_w(RD_VRES + 1);

  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(BURSTS - 1);
  localparam logic [LINE_W-1:0]  LAST_LINE  = LINE_W'(RD_VRES);
  localparam logic [ADDR_W-1:0]  BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0]  STRIDE     = ADDR_W'(LINE_STRIDE);
  localparam logic [ADDR_W-1:0]  BURST_INC  = ADDR_W'(BURST_LEN);

  fetch_state_t         state_q, state_d;
  logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [LINE_W-1:0]    line_cnt_q, line_cnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W-1:0]    line_base_q, line_base_d;
  logic [LB_BANKS-1:0]  full_q, full_d;
  logic                 wr_sel_q, wr_sel_d;
  logic                 rd_sel_q, rd_sel_d;
  logic                 underrun_q, underrun_d;
  logic [7:0]           len_q, len_d;
  logic                 restart;

  logic vs_rise, vs_fall_unused, rden_rise, rden_fall;

  vid_edge_det u_vs_edge (
    .clk_i  (I_pxl_clk),
    .rst_ni (I_rst_n),
    .sig_i  (I_vs),
    .rise_o (vs_rise),
    .fall_o (vs_fall_unused)
  );

  vid_edge_det u_rden_edge (
    .clk_i  (I_pxl_clk),
    .rst_ni (I_rst_n),
    .sig_i  (I_rden),
    .rise_o (rden_rise),
    .fall_o (rden_fall)
  );

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    burst_cnt_d = burst_cnt_q;
    line_cnt_d  = line_cnt_q;
    addr_d      = addr_q;
    line_base_d = line_base_q;
    full_d      = full_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    underrun_d  = underrun_q;
    len_d       = len_q;
    restart     = 1'b0;

    if (rden_rise && !full_q[rd_sel_q]) begin
      underrun_d = 1'b1;
    end
    // Release happens before the NEXT check so a freed bank is usable in the same cycle.
    if (rden_fall) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end

    unique case (state_q)
      IDLE: begin
        if (vs_rise) restart = 1'b1;
      end
      CMD: begin
        if (vs_rise) begin
          restart = 1'b1;
        end else if (I_cmd_ready) begin
          state_d    = DATA;
          beat_cnt_d = '0;
        end
      end
      DATA: begin
        if (I_rd_dvalid) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            addr_d     = addr_q + BURST_INC;
            if (burst_cnt_q == LAST_BURST) begin
              burst_cnt_d      = '0;
              full_d[wr_sel_q] = 1'b1;
              wr_sel_d         = ~wr_sel_q;
              line_cnt_d       = line_cnt_q + LINE_W'(1);
              line_base_d      = line_base_q + STRIDE;
              addr_d           = line_base_q + STRIDE;
              state_d          = NEXT;
            end else begin
              burst_cnt_d = burst_cnt_q + BURST_W'(1);
              state_d     = CMD;
            end
          end
        end
        // A burst that completes on the vs_rise cycle leaves nothing to drain.
        if (vs_rise) begin
          if (I_rd_dvalid && beat_cnt_q == LAST_BEAT) begin
            restart = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      NEXT: begin
        if (vs_rise) begin
          restart = 1'b1;
        end else if (line_cnt_q == LAST_LINE) begin
          state_d = IDLE;
        end else if (!full_d[wr_sel_q]) begin
          state_d = CMD;
        end
      end
      DRAIN: begin
        if (I_rd_dvalid) begin
          if (beat_cnt_q == LAST_BEAT) begin
            restart = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (restart) begin
      state_d     = CMD;
      beat_cnt_d  = '0;
      burst_cnt_d = '0;
      line_cnt_d  = '0;
      addr_d      = BASE;
      line_base_d = BASE;
      full_d      = '0;
      wr_sel_d    = 1'b0;
      rd_sel_d    = 1'b0;
      underrun_d  = 1'b0;
      len_d       = 8'(BURST_LEN);
    end
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      burst_cnt_q <= '0;
      line_cnt_q  <= '0;
      addr_q      <= '0;
      line_base_q <= '0;
      full_q      <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      underrun_q  <= 1'b0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      line_cnt_q  <= line_cnt_d;
      addr_q      <= addr_d;
      line_base_q <= line_base_d;
      full_q      <= full_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      underrun_q  <= underrun_d;
      len_q       <= len_d;
    end
  end

  assign O_cmd_valid = (state_q == CMD);
  assign O_cmd_addr  = addr_q;
  assign O_cmd_len   = len_q;
  assign O_lb_wr_en  = I_rd_dvalid & ((state_q == DATA) | (state_q == DRAIN));
  assign O_lb_wr_sel = wr_sel_q;
  assign O_lb_rd_sel = rd_sel_q;
  assign O_underrun  = underrun_q;
  assign O_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_line_fetch_ctrl.sv
// tb/tb_line_fetch_ctrl.sv - directed and randomized checks of line_fetch_ctrl against a frame-level model.
module tb_line_fetch_ctrl;

  localparam int HRES   = 64;
  localparam int VRES   = 6;
  localparam int BL     = 8;
  localparam int STRIDE = 80;
  localparam int BASE   = 1000;
  localparam int AW     = 10;
  localparam int BURSTS = HRES / BL;

  localparam int P_IDLE = 0, P_REQ = 1, P_RECV = 2, P_WAIT = 3, P_DRAIN = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vs = 1'b0, rden = 1'b0, cmd_ready = 1'b0, rd_dvalid = 1'b0;
  logic          cmd_valid, lb_wr_en, lb_wr_sel, lb_rd_sel, underrun, busy;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;

  always #5 clk = ~clk;

  line_fetch_ctrl #(
    .RD_HRES(HRES), .RD_VRES(VRES), .BURST_LEN(BL),
    .LINE_STRIDE(STRIDE), .BASE_ADDR(BASE), .ADDR_W(AW)
  ) dut (
    .I_pxl_clk   (clk),
    .I_rst_n     (rst_n),
    .I_vs        (vs),
    .I_rden      (rden),
    .O_cmd_valid (cmd_valid),
    .I_cmd_ready (cmd_ready),
    .O_cmd_addr  (cmd_addr),
    .O_cmd_len   (cmd_len),
    .I_rd_dvalid (rd_dvalid),
    .O_lb_wr_en  (lb_wr_en),
    .O_lb_wr_sel (lb_wr_sel),
    .O_lb_rd_sel (lb_rd_sel),
    .O_underrun  (underrun),
    .O_busy      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;

  // Frame-level model: k = bursts completed this frame, lines/falls counted, banks by parity.
  int ph, k, beats, lines_done, falls, cmds;
  bit started, und, vs_p, rden_p;
  bit full[2];

  task automatic finish_up();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    ph = P_IDLE; k = 0; beats = 0; lines_done = 0; falls = 0; cmds = 0;
    started = 1'b0; und = 1'b0; vs_p = 1'b0; rden_p = 1'b0;
    full = '{1'b0, 1'b0};
  endtask

  task automatic check_outputs();
    int ea;
    ea = started ? (BASE + (k / BURSTS) * STRIDE + (k % BURSTS) * BL) % (1 << AW) : 0;
    chk("cmd_valid", 32'(cmd_valid), 32'(ph == P_REQ));
    chk("busy",      32'(busy),      32'(ph != P_IDLE));
    chk("lb_wr_en",  32'(lb_wr_en),  32'(rd_dvalid && (ph == P_RECV || ph == P_DRAIN)));
    chk("cmd_addr",  32'(cmd_addr),  32'(ea));
    chk("cmd_len",   32'(cmd_len),   started ? 32'(BL) : 32'd0);
    chk("wr_sel",    32'(lb_wr_sel), 32'(lines_done % 2));
    chk("rd_sel",    32'(lb_rd_sel), 32'(falls % 2));
    chk("underrun",  32'(underrun),  32'(und));
  endtask

  task automatic model_step();
    bit vsr, rr, rf, rs, done;
    bit nf[2];
    vsr = vs && !vs_p;
    rr  = rden && !rden_p;
    rf  = !rden && rden_p;
    rs  = 1'b0;
    done = 1'b0;
    nf  = full;
    if (cmd_valid && cmd_ready && !vsr) cmds++;
    if (rr && !full[falls % 2]) und = 1'b1;
    if (rf) begin
      nf[falls % 2] = 1'b0;
      falls++;
    end
    case (ph)
      P_IDLE: if (vsr) rs = 1'b1;
      P_REQ: begin
        if (vsr) rs = 1'b1;
        else if (cmd_ready) begin ph = P_RECV; beats = 0; end
      end
      P_RECV: begin
        if (rd_dvalid) begin
          beats++;
          if (beats == BL) begin
            done = 1'b1; beats = 0; k++;
            if (k % BURSTS == 0) begin
              nf[lines_done % 2] = 1'b1;
              lines_done++;
              ph = P_WAIT;
            end else begin
              ph = P_REQ;
            end
          end
        end
        if (vsr) begin
          if (done) rs = 1'b1;
          else ph = P_DRAIN;
        end
      end
      P_WAIT: begin
        if (vsr) rs = 1'b1;
        else if (lines_done == VRES) ph = P_IDLE;
        else if (!nf[lines_done % 2]) ph = P_REQ;
      end
      P_DRAIN: begin
        if (rd_dvalid) begin
          beats++;
          if (beats == BL) rs = 1'b1;
        end
      end
      default: ph = P_IDLE;
    endcase
    if (rs) begin
      ph = P_REQ; k = 0; beats = 0; lines_done = 0; falls = 0; cmds = 0;
      full = '{1'b0, 1'b0}; und = 1'b0; started = 1'b1;
    end else begin
      full = nf;
    end
    vs_p = vs;
    rden_p = rden;
  endtask

  task automatic cyc(input bit v, input bit r, input bit rdy, input bit dv);
    @(negedge clk);
    vs = v; rden = r; cmd_ready = rdy; rd_dvalid = dv;
    #1;
    check_outputs();
    model_step();
    t++;
    if (n_fail > 40) finish_up();
  endtask

  task automatic pulse_vs();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run(input int n, input int rpct, input int dpct, input int vs_permil,
                     input bit rd_en, input int per, input int on_len);
    int vs_left;
    bit v;
    vs_left = 0;
    for (int i = 0; i < n; i++) begin
      if (vs_left == 0 && $urandom_range(999) < vs_permil) vs_left = 3;
      v = (vs_left > 1);
      if (vs_left > 0) vs_left--;
      cyc(v, rd_en && ((t % per) < on_len),
          $urandom_range(99) < rpct, $urandom_range(99) < dpct);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Two lines fetched back to back, then the fetcher waits for a free bank.
    pulse_vs();
    run(200, 100, 100, 0, 1'b0, 1, 0);
    chk("s1_cmds", 32'(cmds), 32'(2 * BURSTS));
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_wr_sel", 32'(lb_wr_sel), 32'd0);

    // A display window frees bank 0; the next command is held while ready is low.
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("s2_valid_hold", 32'(cmd_valid), 32'd1);
      chk("s2_addr_hold", 32'(cmd_addr), 32'((BASE + 2 * STRIDE) % (1 << AW)));
    end
    chk("s2_rd_sel", 32'(lb_rd_sel), 32'd1);
    run(300, 100, 100, 0, 1'b0, 1, 0);

    // Whole frame under random back-pressure with periodic display windows.
    pulse_vs();
    run(2500, 60, 70, 0, 1'b1, 150, 80);
    chk("s3_idle", 32'(busy), 32'd0);
    chk("s3_cmds", 32'(cmds), 32'(VRES * BURSTS));

    // Underrun: display window opens before line 0 has arrived.
    pulse_vs();
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("s4_underrun_set", 32'(underrun), 32'd1);
    run(300, 100, 100, 0, 1'b1, 150, 80);
    chk("s4_underrun_held", 32'(underrun), 32'd1);
    for (int i = 0; i < 2 * BL; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    pulse_vs();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s4_underrun_clr", 32'(underrun), 32'd0);

    // vs_rise mid-burst: remaining beats drained, second vs_rise in DRAIN ignored.
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s5_valid", 32'(cmd_valid), 32'd1);
    chk("s5_addr", 32'(cmd_addr), 32'(BASE % (1 << AW)));
    chk("s5_wr_sel", 32'(lb_wr_sel), 32'd0);

    // Random traffic including random frame starts.
    run(3000, 50, 50, 4, 1'b1, 97, 40);

    // Asynchronous reset in mid-operation.
    @(negedge clk);
    vs = 1'b0; rden = 1'b0; cmd_ready = 1'b0; rd_dvalid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulse_vs();
    run(200, 80, 80, 0, 1'b1, 60, 30);

    finish_up();
  end

endmodule
